operand_fetch: RTL and testbench

- Core-side initiator of the register file interface: drives the three read ports and the single write port.
- Sits between decode (ID) and execute (EX). Reads operands, forwards same-cycle writebacks, and keeps a busy-register scoreboard that stalls RAW/WAW hazards.
- Arbitrates ALU and load writebacks onto the one write port.
- Registers the issued instruction into a one-entry EX output stage with valid/ready handshake.

---
 rtl/core_pkg.sv | 34 +++
 rtl/regfile_if.sv | 18 +
 rtl/reg_scoreboard.sv | 69 ++++++
 rtl/operand_fetch.sv | 115 +++++++++++
 tb/tb_operand_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types: register index/word typedefs, id_use bit positions, EX stage packet.
// Also holds the operand bypass helper used by the operand fetch stage.
package core_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  word_t;

    localparam int SRC_RS1 = 0;
    localparam int SRC_RS2 = 1;
    localparam int SRC_RS3 = 2;

    typedef struct packed {
        word_t    rs1_val;
        word_t    rs2_val;
        word_t    rs3_val;
        reg_idx_t rd;
        logic     wr;
        logic     is_load;
    } ex_pkt_t;

    // r0 reads as zero; a same-cycle winning writeback overrides the stale regfile value.
    function automatic word_t fwd_operand(input reg_idx_t idx, input logic wb_w,
                                          input reg_idx_t wb_rd, input word_t wb_val,
                                          input word_t rf_val);
        if (idx == '0)
            return '0;
        else if (wb_w && (wb_rd == idx))
            return wb_val;
        else
            return rf_val;
    endfunction
endpackage

// File: rtl/regfile_if.sv
// Register file interface: three combinational read ports and one write port.
// The core modport initiates addresses and write data; the rf modport answers reads.
interface regfile_if;
    core_pkg::reg_idx_t rs1;
    core_pkg::reg_idx_t rs2;
    core_pkg::reg_idx_t rs3;
    core_pkg::word_t    rs1_val;
    core_pkg::word_t    rs2_val;
    core_pkg::word_t    rs3_val;
    core_pkg::reg_idx_t rd;
    core_pkg::word_t    rd_val;
    logic               w_rd;

    modport core (output rs1, rs2, rs3, rd, rd_val, w_rd,
                  input  rs1_val, rs2_val, rs3_val);
    modport rf   (input  rs1, rs2, rs3, rd, rd_val, w_rd,
                  output rs1_val, rs2_val, rs3_val);
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard and outstanding-load counter; flags RAW/WAW hazards and load-limit stalls.
// Latency: hazard/stall are combinational; busy/count update on the next clock edge.
// Backpressure: a set for the same register as this cycle's clear wins, keeping the new producer tracked.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int LOAD_Q_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_vld,
    input  logic [REG_W-1:0] clr_rd,
    input  logic           set_vld,
    input  logic [REG_W-1:0] set_rd,
    input  logic [REG_W-1:0] src_rs1,
    input  logic [REG_W-1:0] src_rs2,
    input  logic [REG_W-1:0] src_rs3,
    input  logic [2:0]     src_use,
    input  logic           dst_wr,
    input  logic [REG_W-1:0] dst_rd,
    input  logic           is_load,
    input  logic           ld_acc,
    input  logic           ld_wb_hs,
    output logic           hazard,
    output logic           ld_stall
);
    localparam logic [3:0] DEPTH_C = 4'(LOAD_Q_DEPTH);

    logic [31:0] busy_q, busy_d;
    logic [31:0] clr_mask, set_mask, live;
    logic [3:0]  ld_cnt_q, ld_cnt_d;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_vld && (clr_rd != '0)) clr_mask[clr_rd] = 1'b1;
        if (set_vld && (set_rd != '0)) set_mask[set_rd] = 1'b1;
        live      = busy_q & ~clr_mask;
        busy_d    = live | set_mask;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hazard = (src_use[SRC_RS1] && live[src_rs1]) ||
                 (src_use[SRC_RS2] && live[src_rs2]) ||
                 (src_use[SRC_RS3] && live[src_rs3]) ||
                 (dst_wr && (dst_rd != '0) && live[dst_rd]);
        ld_stall = is_load && (ld_cnt_q == DEPTH_C) && !ld_wb_hs;
    end

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        case ({ld_acc, ld_wb_hs})
            2'b10:   ld_cnt_d = ld_cnt_q + 4'd1;
            2'b01:   ld_cnt_d = ld_cnt_q - 4'd1;
            default: ld_cnt_d = ld_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            ld_cnt_q <= '0;
        end else begin
            busy_q   <= busy_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch between ID and EX: regfile reads with writeback bypass, ALU-over-load write arbitration.
// Latency: one cycle from ID accept to ex_valid.
// Backpressure: id_ready drops on EX full without ex_ready, scoreboard hazard, or load-limit stall.
module operand_fetch
    import core_pkg::*;
#(
    parameter int LOAD_Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rs3,
    input  logic [2:0]       id_use,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr,
    input  logic             id_is_load,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_rs3_val,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_wr,
    output logic             ex_is_load,
    input  logic             alu_wb_valid,
    input  logic [REG_W-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]  alu_wb_val,
    input  logic             ld_wb_valid,
    output logic             ld_wb_ready,
    input  logic [REG_W-1:0] ld_wb_rd,
    input  logic [XLEN-1:0]  ld_wb_val,
    regfile_if.core          rif
);
    logic     wb_vld, wb_w, ld_wb_hs;
    reg_idx_t wb_rd;
    word_t    wb_val;
    logic     hazard, ld_stall, accept;
    logic     ex_valid_q, ex_valid_d;
    ex_pkt_t  ex_q, ex_d;

    always_comb begin
        wb_vld      = alu_wb_valid || ld_wb_valid;
        wb_rd       = alu_wb_valid ? alu_wb_rd  : ld_wb_rd;
        wb_val      = alu_wb_valid ? alu_wb_val : ld_wb_val;
        wb_w        = rst_n && wb_vld && (wb_rd != '0);
        ld_wb_ready = !alu_wb_valid;
        ld_wb_hs    = ld_wb_valid && ld_wb_ready;
    end

    assign rif.rs1    = id_rs1;
    assign rif.rs2    = id_rs2;
    assign rif.rs3    = id_rs3;
    assign rif.rd     = wb_rd;
    assign rif.rd_val = wb_val;
    assign rif.w_rd   = wb_w;

    reg_scoreboard #(.LOAD_Q_DEPTH(LOAD_Q_DEPTH)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_vld  (wb_vld),
        .clr_rd   (wb_rd),
        .set_vld  (accept && id_wr),
        .set_rd   (id_rd),
        .src_rs1  (id_rs1),
        .src_rs2  (id_rs2),
        .src_rs3  (id_rs3),
        .src_use  (id_use),
        .dst_wr   (id_wr),
        .dst_rd   (id_rd),
        .is_load  (id_is_load),
        .ld_acc   (accept && id_is_load),
        .ld_wb_hs (ld_wb_hs),
        .hazard   (hazard),
        .ld_stall (ld_stall)
    );

    always_comb begin
        id_ready   = (!ex_valid_q || ex_ready) && !hazard && !ld_stall;
        accept     = id_valid && id_ready;
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (accept) begin
            ex_d.rs1_val = fwd_operand(id_rs1, wb_w, wb_rd, wb_val, rif.rs1_val);
            ex_d.rs2_val = fwd_operand(id_rs2, wb_w, wb_rd, wb_val, rif.rs2_val);
            ex_d.rs3_val = fwd_operand(id_rs3, wb_w, wb_rd, wb_val, rif.rs3_val);
            ex_d.rd      = id_rd;
            ex_d.wr      = id_wr;
            ex_d.is_load = id_is_load;
            ex_valid_d   = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rs1_val = ex_q.rs1_val;
    assign ex_rs2_val = ex_q.rs2_val;
    assign ex_rs3_val = ex_q.rs3_val;
    assign ex_rd      = ex_q.rd;
    assign ex_wr      = ex_q.wr;
    assign ex_is_load = ex_q.is_load;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: table of per-cycle vectors plus directed reset, load-limit and backpressure sequences.
module tb_operand_fetch;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, tb_init;
    logic       id_valid, id_ready, id_wr, id_is_load, ex_valid, ex_ready, ex_wr, ex_is_load;
    reg_idx_t   id_rs1, id_rs2, id_rs3, id_rd, ex_rd, alu_wb_rd, ld_wb_rd;
    logic [2:0] id_use;
    word_t      ex_rs1_val, ex_rs2_val, ex_rs3_val, alu_wb_val, ld_wb_val;
    logic       alu_wb_valid, ld_wb_valid, ld_wb_ready;

    regfile_if rif ();

    operand_fetch #(.LOAD_Q_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_use(id_use),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs3_val(ex_rs3_val),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_val(alu_wb_val),
        .ld_wb_valid(ld_wb_valid), .ld_wb_ready(ld_wb_ready),
        .ld_wb_rd(ld_wb_rd), .ld_wb_val(ld_wb_val),
        .rif(rif)
    );

    // Register file model: unwritten entries read 0x1000_0000 + index (r0 deliberately nonzero).
    logic [31:0] written;
    word_t       mem [32];
    always @(posedge clk) begin
        if (!tb_init) written <= '0;
        else if (rif.w_rd) begin
            written[rif.rd] <= 1'b1;
            mem[rif.rd]     <= rif.rd_val;
        end
    end
    assign rif.rs1_val = written[rif.rs1] ? mem[rif.rs1] : (32'h1000_0000 | 32'(rif.rs1));
    assign rif.rs2_val = written[rif.rs2] ? mem[rif.rs2] : (32'h1000_0000 | 32'(rif.rs2));
    assign rif.rs3_val = written[rif.rs3] ? mem[rif.rs3] : (32'h1000_0000 | 32'(rif.rs3));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_use = 0;
        id_rd = 0; id_wr = 0; id_is_load = 0; ex_ready = 1;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_val = 0;
        ld_wb_valid = 0; ld_wb_rd = 0; ld_wb_val = 0;
    endtask

    task automatic set_id(input logic v, input reg_idx_t rs1, input logic [2:0] use_m,
                          input reg_idx_t rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = rs1; id_use = use_m; id_rd = rd; id_wr = wr; id_is_load = ld;
    endtask

    task automatic rst_pulse();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    typedef struct {
        logic v; reg_idx_t rs1; logic [2:0] use_m; reg_idx_t rd; logic wr; logic ld; logic exr;
        logic av; reg_idx_t ard; word_t aval;
        logic lv; reg_idx_t lrd; word_t lval;
        logic e_rdy; logic e_lrdy; logic e_w; reg_idx_t e_rd; word_t e_val;
        logic e_exv; logic chk_rs1; word_t e_rs1;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input reg_idx_t rs1, input logic [2:0] use_m, input reg_idx_t rd,
        input logic wr, input logic ld, input logic exr,
        input logic av, input reg_idx_t ard, input word_t aval,
        input logic lv, input reg_idx_t lrd, input word_t lval,
        input logic e_rdy, input logic e_lrdy, input logic e_w, input reg_idx_t e_rd, input word_t e_val,
        input logic e_exv, input logic chk_rs1, input word_t e_rs1);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.use_m = use_m; t.rd = rd; t.wr = wr; t.ld = ld; t.exr = exr;
        t.av = av; t.ard = ard; t.aval = aval; t.lv = lv; t.lrd = lrd; t.lval = lval;
        t.e_rdy = e_rdy; t.e_lrdy = e_lrdy; t.e_w = e_w; t.e_rd = e_rd; t.e_val = e_val;
        t.e_exv = e_exv; t.chk_rs1 = chk_rs1; t.e_rs1 = e_rs1;
        return t;
    endfunction

    vec_t vt [13];

    initial begin
        // RAW on load, bypass, arbitration, r0, WAW with set-beats-clear.
        vt[0]  = mk(1, 1, 3'b000, 5, 1, 1, 1,  0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0,            1, 1, 32'h1000_0001);
        vt[1]  = mk(1, 5, 3'b001, 6, 1, 0, 1,  0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0,            0, 0, 0);
        vt[2]  = mk(1, 5, 3'b001, 6, 1, 0, 1,  0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0,            0, 0, 0);
        vt[3]  = mk(1, 5, 3'b001, 6, 1, 0, 1,  0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 1, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
        vt[4]  = mk(1, 5, 3'b001, 0, 0, 0, 1,  0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0,            1, 1, 32'hDEADBEEF);
        vt[5]  = mk(1, 1, 3'b000, 4, 1, 1, 1,  1, 3, 32'h1,        1, 4, 32'h2,        1, 0, 1, 3, 32'h1,        1, 0, 0);
        vt[6]  = mk(1, 4, 3'b001, 0, 0, 0, 1,  0, 0, 0,            1, 4, 32'h2,        1, 1, 1, 4, 32'h2,        1, 1, 32'h2);
        vt[7]  = mk(1, 0, 3'b001, 0, 0, 0, 1,  1, 0, 32'hFFFFFFFF, 0, 0, 0,            1, 0, 0, 0, 0,            1, 1, 0);
        vt[8]  = mk(1, 1, 3'b000, 7, 1, 1, 1,  0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0,            1, 0, 0);
        vt[9]  = mk(1, 1, 3'b000, 7, 1, 0, 1,  0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0,            0, 0, 0);
        vt[10] = mk(1, 1, 3'b000, 7, 1, 0, 1,  1, 7, 32'h77,       0, 0, 0,            1, 0, 1, 7, 32'h77,       1, 0, 0);
        vt[11] = mk(1, 7, 3'b001, 0, 0, 0, 1,  0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0,            0, 0, 0);
        vt[12] = mk(0, 0, 3'b000, 0, 0, 0, 1,  0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0,            0, 0, 0);

        tb_init = 0;
        rst_n   = 0;
        idle();
        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_val = 32'h55;
        step();
        step();
        chk1("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_ex_rs1", ex_rs1_val, 32'd0);
        chk("rst_ex_rs2", ex_rs2_val, 32'd0);
        chk("rst_ex_rs3", ex_rs3_val, 32'd0);
        chk1("rst_ex_flags", ex_wr | ex_is_load, 1'b0);
        chk1("rst_w_rd", rif.w_rd, 1'b0);
        idle();
        tb_init = 1;
        rst_n   = 1;
        step();

        // Mid-operation reset with a held EX entry and busy[5].
        ex_ready = 0;
        set_id(1, 1, 3'b000, 5, 1, 1);
        step();
        chk1("pre_rst_ex_valid", ex_valid, 1'b1);
        set_id(0, 0, 0, 0, 0, 0);
        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_val = 32'h66;
        rst_n = 0;
        #1;
        chk1("mid_rst_ex_valid", ex_valid, 1'b0);
        chk1("mid_rst_w_rd", rif.w_rd, 1'b0);
        #1;
        rst_n = 1;
        idle();
        set_id(1, 5, 3'b001, 0, 0, 0);
        #1;
        chk1("post_rst_id_ready", id_ready, 1'b1);
        step();

        for (int i = 0; i < 13; i++) begin
            id_valid = vt[i].v; id_rs1 = vt[i].rs1; id_use = vt[i].use_m; id_rd = vt[i].rd;
            id_wr = vt[i].wr; id_is_load = vt[i].ld; ex_ready = vt[i].exr;
            alu_wb_valid = vt[i].av; alu_wb_rd = vt[i].ard; alu_wb_val = vt[i].aval;
            ld_wb_valid = vt[i].lv; ld_wb_rd = vt[i].lrd; ld_wb_val = vt[i].lval;
            #1;
            chk1($sformatf("v%0d_id_ready", i), id_ready, vt[i].e_rdy);
            chk1($sformatf("v%0d_ld_wb_ready", i), ld_wb_ready, vt[i].e_lrdy);
            chk1($sformatf("v%0d_w_rd", i), rif.w_rd, vt[i].e_w);
            if (vt[i].e_w) begin
                chk($sformatf("v%0d_rd", i), 32'(rif.rd), 32'(vt[i].e_rd));
                chk($sformatf("v%0d_rd_val", i), rif.rd_val, vt[i].e_val);
            end
            step();
            chk1($sformatf("v%0d_ex_valid", i), ex_valid, vt[i].e_exv);
            if (vt[i].chk_rs1)
                chk($sformatf("v%0d_ex_rs1", i), ex_rs1_val, vt[i].e_rs1);
        end

        // Load limit: four outstanding, fifth stalls until a load writeback handshake.
        idle();
        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            set_id(1, 0, 3'b000, reg_idx_t'(8 + i), 1, 1);
            #1;
            chk1($sformatf("ld%0d_id_ready", i), id_ready, 1'b1);
            step();
        end
        set_id(1, 0, 3'b000, 12, 1, 1);
        #1;
        chk1("ld5_stall", id_ready, 1'b0);
        step();
        ld_wb_valid = 1; ld_wb_rd = 8; ld_wb_val = 32'h88;
        #1;
        chk1("ld5_wb_ready", ld_wb_ready, 1'b1);
        chk1("ld5_accept", id_ready, 1'b1);
        step();
        ld_wb_valid = 0;
        set_id(1, 0, 3'b000, 13, 1, 1);
        #1;
        chk1("ld6_stall_cnt4", id_ready, 1'b0);
        step();
        ld_wb_valid = 1; ld_wb_rd = 9; ld_wb_val = 32'h99;
        #1;
        chk1("ld6_accept", id_ready, 1'b1);
        step();

        // Backpressure: EX held for three cycles, then drained.
        idle();
        rst_pulse();
        ex_ready = 0;
        set_id(1, 1, 3'b000, 20, 0, 0);
        #1;
        chk1("bp_a_id_ready", id_ready, 1'b1);
        step();
        chk1("bp_a_ex_valid", ex_valid, 1'b1);
        set_id(1, 2, 3'b000, 21, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1($sformatf("bp%0d_id_ready", i), id_ready, 1'b0);
            step();
            chk($sformatf("bp%0d_ex_rs1", i), ex_rs1_val, 32'h1000_0001);
            chk($sformatf("bp%0d_ex_rd", i), 32'(ex_rd), 32'd20);
            chk1($sformatf("bp%0d_ex_valid", i), ex_valid, 1'b1);
        end
        ex_ready = 1;
        #1;
        chk1("bp_b_id_ready", id_ready, 1'b1);
        step();
        chk($sformatf("bp_b_ex_rs1"), ex_rs1_val, 32'h1000_0002);
        chk("bp_b_ex_rd", 32'(ex_rd), 32'd21);
        id_valid = 0;
        step();
        chk1("bp_drain_ex_valid", ex_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
